// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module  : fifo_stream_reader
// Brief   : Pops words from fifo_mem into a 2-entry valid/ready output buffer;
//           streaming, threshold-triggered bursts and timeout single-word flush.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_threshold,
  input  logic                  fifo_underflow,
  input  logic                  burst_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  err_underflow,
  input  logic                  err_clr
);

  localparam int c_BEAT_W = 3;
  localparam int c_TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BURST_LEN - 1);
  localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_BURST  = 2'd2,
    S_SINGLE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_BEAT_W-1:0]   r_beat_cnt;
  logic [c_BEAT_W-1:0]   w_beat_nxt;
  logic [c_TMO_W-1:0]    r_tmo_cnt;
  logic [c_TMO_W-1:0]    w_tmo_nxt;
  logic                  w_pop_ok;
  logic                  w_push_last;
  logic                  w_take;
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;
  logic                  r_last0;
  logic                  r_last1;

  // Pop permission depends on registered state only, so fifo_rd has no input-to-state loop.
  assign w_pop_ok    = (r_state != S_IDLE);
  assign w_push_last = (r_state == S_SINGLE) ||
                       ((r_state == S_BURST) && (r_beat_cnt == c_BEAT_LAST));
  assign fifo_rd     = w_pop_ok & ~fifo_empty & (r_occ != 2'd2);

  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_data0;
  assign m_last  = r_last0 & m_valid;
  assign w_take  = m_valid & m_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_tmo_nxt   = r_tmo_cnt;
    case (r_state)
      S_IDLE: begin
        if (!burst_en && !fifo_empty) begin
          w_state_nxt = S_STREAM;
          w_tmo_nxt   = '0;
        end else if (burst_en && fifo_threshold) begin
          w_state_nxt = S_BURST;
          w_beat_nxt  = '0;
          w_tmo_nxt   = '0;
        end else if (burst_en && !fifo_empty) begin
          if (r_tmo_cnt == c_TMO_LAST) begin
            w_state_nxt = S_SINGLE;
            w_tmo_nxt   = '0;
          end else begin
            w_tmo_nxt = r_tmo_cnt + 1'b1;
          end
        end else begin
          w_tmo_nxt = '0;
        end
      end
      S_STREAM: begin
        if (fifo_empty || burst_en) w_state_nxt = S_IDLE;
      end
      S_BURST: begin
        if (fifo_rd) begin
          if (r_beat_cnt == c_BEAT_LAST) begin
            w_beat_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_beat_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      S_SINGLE: begin
        if (fifo_rd) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
    end
  end

  // Head entry drives the stream; a push while only the head is occupied lands in entry 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ   <= 2'd0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      case ({fifo_rd, w_take})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_data0 <= fifo_data_out;
            r_last0 <= w_push_last;
          end else begin
            r_data1 <= fifo_data_out;
            r_last1 <= w_push_last;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_last0 <= r_last1;
          r_occ   <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_data0 <= fifo_data_out;
            r_last0 <= w_push_last;
          end else begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
            r_data1 <= fifo_data_out;
            r_last1 <= w_push_last;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (fifo_underflow) begin
      err_underflow <= 1'b1;
    end else if (err_clr) begin
      err_underflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_stream_reader
// Brief   : Scoreboard bench for fifo_stream_reader with a behavioural fifo_mem.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_rd;
  logic [7:0] fifo_data_out = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_threshold = 1'b0;
  logic       fifo_underflow = 1'b0;
  logic       burst_en = 1'b0;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready = 1'b0;
  logic       err_underflow;
  logic       err_clr = 1'b0;

  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fq[$];
  logic [8:0] exp_q[$];
  logic [8:0] exp_e;
  logic       stall_prev = 1'b0;
  logic [8:0] hold_prev = 9'h0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4), .TIMEOUT(32)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rd(fifo_rd), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_threshold(fifo_threshold), .fifo_underflow(fifo_underflow),
    .burst_en(burst_en), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .err_underflow(err_underflow), .err_clr(err_clr)
  );

  // Show-ahead fifo_mem model with registered flags; threshold at >= 8 words.
  always @(posedge clk) begin
    if (fifo_rd && fq.size() > 0) void'(fq.pop_front());
    if (wr_en) fq.push_back(wr_data);
    fifo_empty     <= (fq.size() == 0);
    fifo_threshold <= (fq.size() >= 8);
    fifo_data_out  <= (fq.size() > 0) ? fq[0] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: transfers and hold-stability observed at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (fifo_rd) check("fifo_rd_when_empty", {31'd0, fifo_empty}, 32'd0);
      if (stall_prev) check("hold_stable", {22'd0, m_valid, m_last, m_data}, {22'd0, 1'b1, hold_prev});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got last=%0b data=0x%0h, expected no beat", m_last, m_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("beat {last,data}", {23'd0, m_last, m_data}, {23'd0, exp_e});
        end
      end
      stall_prev = m_valid && !m_ready;
      hold_prev  = {m_last, m_data};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d beats pending, expected 0 after %0d cycles", name, exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    check("rst_err", {31'd0, err_underflow}, 32'd0);
    rst_n = 1'b1;
    step();

    // Streaming: 0x01..0x10, never tagged last
    burst_en = 1'b0;
    m_ready  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      exp_q.push_back({1'b0, 8'(i)});
      step();
    end
    wr_en = 1'b0;
    wait_drain(200, "stream");

    // Burst: 12 words -> two 4-beat bursts, then four timeout singles
    burst_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h11 + 8'(i);
      exp_q.push_back({(i == 3 || i == 7 || i >= 8), 8'h11 + 8'(i)});
      step();
    end
    wr_en = 1'b0;
    wait_drain(1000, "burst");

    // Backpressure mid-burst
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h20 + 8'(i);
      exp_q.push_back({(i >= 3), 8'h20 + 8'(i)});
      step();
    end
    wr_en = 1'b0;
    begin
      int k = 0;
      while (exp_q.size() > 7 && k < 50) begin
        step();
        k++;
      end
      check("bp_first_beat_seen", {31'd0, (exp_q.size() <= 7)}, 32'd1);
    end
    m_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c >= 3) check("bp_fifo_rd_low", {31'd0, fifo_rd}, 32'd0);
    end
    m_ready = 1'b1;
    wait_drain(600, "backpressure");

    // Reset during burst beat 2 with the buffer full
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h40 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_m_data", {24'd0, m_data}, 32'd0);
    check("mid_rst_m_last", {31'd0, m_last}, 32'd0);
    check("mid_rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back({(i >= 3), 8'h42 + 8'(i)});
    step();
    check("post_rst_no_stale_valid", {31'd0, m_valid}, 32'd0);
    m_ready = 1'b1;
    wait_drain(800, "reset_restart");

    // Sticky underflow error
    check("err_idle", {31'd0, err_underflow}, 32'd0);
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    check("err_set", {31'd0, err_underflow}, 32'd1);
    repeat (3) step();
    check("err_sticky", {31'd0, err_underflow}, 32'd1);
    fifo_underflow = 1'b1;
    err_clr = 1'b1;
    step();
    fifo_underflow = 1'b0;
    check("err_set_wins", {31'd0, err_underflow}, 32'd1);
    step();
    err_clr = 1'b0;
    check("err_cleared", {31'd0, err_underflow}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
